// File: rtl/pipeline_ctrl_fsm_pkg.sv
// Shared types and constants for the pipeline stall/flush controller:
// state encodings, counter widths, interrupt vector and the per-stage control bundle.
package pipeline_ctrl_fsm_pkg;

  localparam int unsigned CNT_W       = 4;
  localparam int unsigned STALL_CNT_W = 16;
  localparam int unsigned STATE_W     = 3;

  localparam logic [15:0] IRQ_VECTOR = 16'h0010;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN    = 3'd0,
    ST_MWAIT  = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_VECTOR = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  // Per-cycle pipeline control decode, MSB first: stalls, flushes, vector select, ack.
  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic pc_sel_vec;
    logic irq_ack;
  } ctrl_t;

endpackage

// File: rtl/pipeline_ctrl_fsm_if.sv
// Hazard/memory request inputs and pipeline control outputs of the controller.
// master = hazard unit / memory side, slave = controller.
interface pipeline_ctrl_fsm_if
  import pipeline_ctrl_fsm_pkg::*;
#(
  parameter int unsigned PC_W = 16
);
  logic                   lw_hazard;
  logic                   branch_taken;
  logic                   mem_busy;
  logic                   halt_dec;
  logic                   resume;
  logic                   irq_req;
  logic                   irq_en;
  logic [PC_W-1:0]        pc_d;
  logic                   stallF;
  logic                   stallD;
  logic                   stallE;
  logic                   stallM;
  logic                   flushD;
  logic                   flushE;
  logic                   pc_sel_vec;
  logic                   irq_ack;
  logic [PC_W-1:0]        epc;
  logic [STALL_CNT_W-1:0] stall_cycles;

  modport master (
    output lw_hazard, branch_taken, mem_busy, halt_dec, resume, irq_req, irq_en, pc_d,
    input  stallF, stallD, stallE, stallM, flushD, flushE, pc_sel_vec, irq_ack, epc, stall_cycles
  );

  modport slave (
    input  lw_hazard, branch_taken, mem_busy, halt_dec, resume, irq_req, irq_en, pc_d,
    output stallF, stallD, stallE, stallM, flushD, flushE, pc_sel_vec, irq_ack, epc, stall_cycles
  );
endinterface

// File: rtl/pipeline_ctrl_fsm_drain_counter.sv
// drain_counter: 4-bit load/hold/decrement counter with a zero flag,
// timing the front-end squash before interrupt vectoring.
module pipeline_ctrl_fsm_drain_counter
  import pipeline_ctrl_fsm_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_c
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                      cnt_d = load_val;
    else if (dec && cnt_q != '0)   cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_c = (cnt_q == '0);
endmodule

// File: rtl/pipeline_ctrl_fsm.sv
// Stall/flush sequencer for the 5-stage pipeline (Mealy control outputs).
// Define STALL_COUNTER_EN to build the saturating stallF-cycle performance counter.
module pipeline_ctrl_fsm
  import pipeline_ctrl_fsm_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned PC_W         = 16
)(
  input  logic              clk,
  input  logic              reset,
  pipeline_ctrl_fsm_if.slave bus
);
  state_e          state_q, state_d;
  logic [PC_W-1:0] epc_q, epc_d;
  ctrl_t           ctrl_c;
  logic            irq_c;
  logic            cnt_load_c, cnt_dec_c, cnt_zero_c;

  assign irq_c = bus.irq_req & bus.irq_en;

  pipeline_ctrl_fsm_drain_counter u_drain_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load_c),
    .load_val (CNT_W'(DRAIN_CYCLES - 1)),
    .dec      (cnt_dec_c),
    .zero_c   (cnt_zero_c)
  );

  // Next-state and per-stage control decode.
  always_comb begin
    state_d    = state_q;
    epc_d      = epc_q;
    ctrl_c     = '0;
    cnt_load_c = 1'b0;
    cnt_dec_c  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.mem_busy) begin
          {ctrl_c.stall_f, ctrl_c.stall_d, ctrl_c.stall_e, ctrl_c.stall_m} = 4'hF;
          state_d = ST_MWAIT;
        end else if (irq_c) begin
          ctrl_c.stall_f = 1'b1;
          ctrl_c.flush_d = 1'b1;
          epc_d          = bus.pc_d;
          cnt_load_c     = 1'b1;
          state_d        = ST_DRAIN;
        end else if (bus.halt_dec) begin
          ctrl_c.stall_f = 1'b1;
          ctrl_c.stall_d = 1'b1;
          ctrl_c.flush_e = 1'b1;
          state_d        = ST_HALTED;
        end else if (bus.lw_hazard) begin
          // A concurrent taken branch is dropped here and re-seen next cycle.
          ctrl_c.stall_f = 1'b1;
          ctrl_c.stall_d = 1'b1;
          ctrl_c.flush_e = 1'b1;
        end else if (bus.branch_taken) begin
          ctrl_c.flush_d = 1'b1;
        end
      end
      ST_MWAIT: begin
        if (bus.mem_busy) {ctrl_c.stall_f, ctrl_c.stall_d, ctrl_c.stall_e, ctrl_c.stall_m} = 4'hF;
        else              state_d = ST_RUN;
      end
      ST_DRAIN: begin
        ctrl_c.stall_f = 1'b1;
        ctrl_c.flush_d = 1'b1;
        if (bus.mem_busy) begin
          {ctrl_c.stall_f, ctrl_c.stall_d, ctrl_c.stall_e, ctrl_c.stall_m} = 4'hF;
        end else if (cnt_zero_c) begin
          state_d = ST_VECTOR;
        end else begin
          cnt_dec_c = 1'b1;
        end
      end
      ST_VECTOR: begin
        ctrl_c.pc_sel_vec = 1'b1;
        ctrl_c.irq_ack    = 1'b1;
        ctrl_c.flush_d    = 1'b1;
        state_d           = ST_RUN;
      end
      ST_HALTED: begin
        ctrl_c.stall_f = 1'b1;
        ctrl_c.stall_d = 1'b1;
        ctrl_c.flush_e = 1'b1;
        if (irq_c) begin
          epc_d      = bus.pc_d;
          cnt_load_c = 1'b1;
          state_d    = ST_DRAIN;
        end else if (bus.resume) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
    // Reset cycle bubbles D and E and suppresses every other control.
    if (reset) begin
      ctrl_c         = '0;
      ctrl_c.flush_d = 1'b1;
      ctrl_c.flush_e = 1'b1;
      cnt_load_c     = 1'b0;
      cnt_dec_c      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
    end
  end

`ifdef STALL_COUNTER_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (ctrl_c.stall_f && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stall_cycles = stall_cnt_q;
`else
  assign bus.stall_cycles = '0;
`endif

  assign bus.stallF     = ctrl_c.stall_f;
  assign bus.stallD     = ctrl_c.stall_d;
  assign bus.stallE     = ctrl_c.stall_e;
  assign bus.stallM     = ctrl_c.stall_m;
  assign bus.flushD     = ctrl_c.flush_d;
  assign bus.flushE     = ctrl_c.flush_e;
  assign bus.pc_sel_vec = ctrl_c.pc_sel_vec;
  assign bus.irq_ack    = ctrl_c.irq_ack;
  assign bus.epc        = epc_q;
endmodule

// File: tb/tb_pipeline_ctrl_fsm.sv
// Directed bench for pipeline_ctrl_fsm: hazards, memory waits, interrupt entry, halt, reset.
module tb_pipeline_ctrl_fsm;
  import pipeline_ctrl_fsm_pkg::*;

  // Output bundle order: stallF stallD stallE stallM flushD flushE pc_sel_vec irq_ack
  localparam logic [7:0] P_IDLE = 8'b0000_0000;
  localparam logic [7:0] P_RST  = 8'b0000_1100;
  localparam logic [7:0] P_HAZ  = 8'b1100_0100;
  localparam logic [7:0] P_BR   = 8'b0000_1000;
  localparam logic [7:0] P_MEM  = 8'b1111_0000;
  localparam logic [7:0] P_DRN  = 8'b1000_1000;
  localparam logic [7:0] P_VEC  = 8'b0000_1011;
`ifdef STALL_COUNTER_EN
  localparam logic [15:0] LW_STALLS = 16'd1;
`else
  localparam logic [15:0] LW_STALLS = 16'd0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipeline_ctrl_fsm_if #(.PC_W(16)) bif ();

  pipeline_ctrl_fsm #(.DRAIN_CYCLES(2), .PC_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  function automatic logic [7:0] outs();
    return {bif.stallF, bif.stallD, bif.stallE, bif.stallM,
            bif.flushD, bif.flushE, bif.pc_sel_vec, bif.irq_ack};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bif.lw_hazard = 0; bif.branch_taken = 0; bif.mem_busy = 0; bif.halt_dec = 0;
    bif.resume = 0; bif.irq_req = 0; bif.irq_en = 0; bif.pc_d = 16'h0000;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (outs() !== P_RST) begin failures++; $display("FAIL reset_outs got=%b exp=%b", outs(), P_RST); end
    checks++;
    if (bif.epc !== 16'h0000) begin failures++; $display("FAIL reset_epc got=%h exp=0000", bif.epc); end
    checks++;
    if (bif.stall_cycles !== 16'h0000) begin failures++; $display("FAIL reset_cnt got=%h exp=0000", bif.stall_cycles); end
    step();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (outs() !== P_IDLE) begin failures++; $display("FAIL run_idle got=%b exp=%b", outs(), P_IDLE); end
    step();
  endtask

  task automatic test_lw_hazard();
    logic [7:0] exp [2];
    exp[0] = P_HAZ; exp[1] = P_IDLE;
    for (int i = 0; i < 2; i++) begin
      bif.lw_hazard = (i == 0);
      @(negedge clk);
      checks++;
      if (outs() !== exp[i]) begin failures++; $display("FAIL lw_hazard c%0d got=%b exp=%b", i, outs(), exp[i]); end
      if (i == 1) begin
        checks++;
        if (bif.stall_cycles !== LW_STALLS) begin
          failures++; $display("FAIL stall_cycles got=%0d exp=%0d", bif.stall_cycles, LW_STALLS);
        end
      end
      step();
    end
  endtask

  task automatic test_lw_branch();
    logic [7:0] exp [3];
    exp[0] = P_HAZ; exp[1] = P_BR; exp[2] = P_IDLE;
    for (int i = 0; i < 3; i++) begin
      bif.lw_hazard    = (i == 0);
      bif.branch_taken = (i < 2);
      @(negedge clk);
      checks++;
      if (outs() !== exp[i]) begin failures++; $display("FAIL lw_branch c%0d got=%b exp=%b", i, outs(), exp[i]); end
      step();
    end
  endtask

  task automatic test_mem_wait();
    logic [7:0] exp [7];
    logic       mb  [7];
    logic       lw  [7];
    logic       irq [7];
    exp = '{P_MEM, P_MEM, P_MEM, P_IDLE, P_IDLE, P_MEM, P_IDLE};
    mb  = '{1, 1, 1, 0, 0, 1, 0};
    lw  = '{0, 0, 0, 1, 0, 0, 0};
    irq = '{0, 0, 0, 0, 0, 1, 0};
    for (int i = 0; i < 7; i++) begin
      bif.mem_busy = mb[i]; bif.lw_hazard = lw[i]; bif.irq_req = irq[i]; bif.irq_en = irq[i];
      @(negedge clk);
      checks++;
      if (outs() !== exp[i]) begin failures++; $display("FAIL mem_wait c%0d got=%b exp=%b", i, outs(), exp[i]); end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_irq_entry();
    logic [7:0] exp [5];
    exp = '{P_DRN, P_DRN, P_DRN, P_VEC, P_IDLE};
    for (int i = 0; i < 5; i++) begin
      bif.irq_req = (i == 0);
      bif.irq_en  = (i == 0);
      bif.pc_d    = (i == 0) ? 16'h0042 : 16'h0099;
      @(negedge clk);
      checks++;
      if (outs() !== exp[i]) begin failures++; $display("FAIL irq_entry c%0d got=%b exp=%b", i, outs(), exp[i]); end
      if (i > 0) begin
        checks++;
        if (bif.epc !== 16'h0042) begin failures++; $display("FAIL irq_epc c%0d got=%h exp=0042", i, bif.epc); end
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_irq_mem_rearm();
    logic [7:0] exp  [10];
    logic [7:0] mask [10];
    logic       irq  [10];
    exp  = '{P_DRN, P_MEM, P_DRN, P_DRN, P_VEC, P_DRN, P_DRN, P_DRN, P_VEC, P_IDLE};
    mask = '{8'hFF, 8'hF0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    irq  = '{1, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      bif.irq_req  = irq[i];
      bif.irq_en   = irq[i];
      bif.mem_busy = (i == 1);
      bif.pc_d     = 16'h0123;
      @(negedge clk);
      checks++;
      if ((outs() & mask[i]) !== exp[i]) begin
        failures++; $display("FAIL irq_mem_rearm c%0d got=%b exp=%b mask=%b", i, outs(), exp[i], mask[i]);
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_halt();
    logic [7:0] exp [11];
    logic       hd  [11];
    logic       rs  [11];
    logic       irq [11];
    exp = '{P_HAZ, P_HAZ, P_HAZ, P_HAZ, P_IDLE, P_HAZ, P_HAZ, P_DRN, P_DRN, P_VEC, P_IDLE};
    hd  = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    rs  = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0};
    irq = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    for (int i = 0; i < 11; i++) begin
      bif.halt_dec = hd[i]; bif.resume = rs[i]; bif.irq_req = irq[i]; bif.irq_en = irq[i];
      bif.pc_d = irq[i] ? 16'h0077 : 16'h0300;
      @(negedge clk);
      checks++;
      if (outs() !== exp[i]) begin failures++; $display("FAIL halt c%0d got=%b exp=%b", i, outs(), exp[i]); end
      step();
    end
    checks++;
    if (bif.epc !== 16'h0077) begin failures++; $display("FAIL halt_epc got=%h exp=0077", bif.epc); end
    clear_inputs();
  endtask

  task automatic test_reset_in_drain();
    logic [7:0] exp [5];
    exp = '{P_DRN, P_RST, P_IDLE, P_IDLE, P_IDLE};
    for (int i = 0; i < 5; i++) begin
      bif.irq_req = (i == 0);
      bif.irq_en  = (i == 0);
      bif.pc_d    = 16'h0055;
      reset       = (i == 1);
      @(negedge clk);
      checks++;
      if (outs() !== exp[i]) begin failures++; $display("FAIL reset_drain c%0d got=%b exp=%b", i, outs(), exp[i]); end
      if (i >= 2) begin
        checks++;
        if (bif.epc !== 16'h0000) begin failures++; $display("FAIL reset_drain_epc c%0d got=%h exp=0000", i, bif.epc); end
      end
      step();
    end
    checks++;
    if (bif.stall_cycles !== 16'h0000) begin
      failures++; $display("FAIL reset_drain_cnt got=%0d exp=0", bif.stall_cycles);
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_lw_hazard();
    test_lw_branch();
    test_mem_wait();
    test_irq_entry();
    test_irq_mem_rearm();
    test_halt();
    test_reset_in_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
